grant_decoder: RTL

- Consumer end of the priority-arbitration path.
- Accepts an encoded grant number plus valid from the arbitration encoder and decodes it to a registered one-hot grant.
- Holds the grant until the granted requester releases it, or until a hold timeout revokes it.
- Sits between a `PriorityEnc`-style arbiter and the requesting units of a shared resource, such as a router output port or a memory port.

---
 rtl/grant_decoder_pkg.sv | 22 ++
 rtl/grant_decoder_dec.sv | 27 ++
 rtl/grant_decoder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/grant_decoder_pkg.sv
// ---------------------------------------------------------------------------
// grant_decoder_pkg
//   Shared types and helpers for the grant-decoder path.
//   - gd_state_e : decoder FSM state (IDLE / GRANT).
//   - idx_w()    : width of an encoded requester index. The arbiter and the
//                  decoder both use it, so the two ends always agree on the
//                  grant-number width for a given NUM_ENTRY.
// ---------------------------------------------------------------------------
package grant_decoder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } gd_state_e;

    // $clog2(n), held at a minimum of 1 so a single-requester build still
    // has a legal (1-bit) index port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/grant_decoder_dec.sv
// ---------------------------------------------------------------------------
// Decoder
//   Combinational index -> one-hot conversion; counterpart of Encoder.
//   Indices >= NUM_ENTRY match no bit position, so the output is all-zero.
//
//   Ports:
//     I_Data  in   idx_w(NUM_ENTRY)  encoded index
//     O_Dec   out  NUM_ENTRY         one-hot of I_Data, zero when out of range
// ---------------------------------------------------------------------------
module Decoder
    import grant_decoder_pkg::*;
#(
    parameter  int NUM_ENTRY = 20,
    localparam int IW        = idx_w(NUM_ENTRY)
) (
    input  logic [IW-1:0]        I_Data,
    output logic [NUM_ENTRY-1:0] O_Dec
);

    always_comb begin
        O_Dec = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            O_Dec[i] = (I_Data == IW'(i));
        end
    end

endmodule

// File: rtl/grant_decoder.sv
// ---------------------------------------------------------------------------
// grant_decoder
//   Consumer end of the priority-arbitration path. Takes an encoded grant
//   number from the arbiter, turns it into a registered one-hot grant and
//   holds it until the holder releases it or the hold timer revokes it.
//
//   Ports:
//     clock      in   1          rising-edge clock
//     reset      in   1          asynchronous active-low reset
//     I_Grt      in   IW         encoded grant number
//     I_Vld      in   1          I_Grt valid
//     O_Rdy      out  1          can accept a grant number (state IDLE)
//     I_Rls      in   NUM_ENTRY  per-requester release; only holder's bit used
//     O_Grt      out  NUM_ENTRY  registered one-hot grant, zero when idle
//     O_Idx      out  IW         holder index, zero when idle
//     O_Busy     out  1          a grant is held
//     O_Timeout  out  1          one-cycle pulse on timeout revocation
//     O_Err      out  1          one-cycle pulse after an out-of-range accept
// ---------------------------------------------------------------------------
module grant_decoder
    import grant_decoder_pkg::*;
#(
    parameter  int NUM_ENTRY = 20,
    parameter  int HOLD_MAX  = 16,
    localparam int IW        = idx_w(NUM_ENTRY)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [IW-1:0]        I_Grt,
    input  logic                 I_Vld,
    output logic                 O_Rdy,
    input  logic [NUM_ENTRY-1:0] I_Rls,
    output logic [NUM_ENTRY-1:0] O_Grt,
    output logic [IW-1:0]        O_Idx,
    output logic                 O_Busy,
    output logic                 O_Timeout,
    output logic                 O_Err
);

    localparam int             CW       = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(HOLD_MAX - 1);
    localparam logic [CW-1:0]  CNT_SAT  = CW'(HOLD_MAX);
    // One extra bit so the range check still works when NUM_ENTRY == 2**IW.
    localparam logic [IW:0]    NE_L     = (IW + 1)'(NUM_ENTRY);

    gd_state_e             state_q, state_d;
    logic [NUM_ENTRY-1:0]  grt_q, grt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  to_q, to_d;
    logic                  err_q, err_d;

    logic [NUM_ENTRY-1:0]  dec_grt;
    logic                  in_range;
    logic                  holder_rls;

    Decoder #(
        .NUM_ENTRY (NUM_ENTRY)
    ) u_dec (
        .I_Data (I_Grt),
        .O_Dec  (dec_grt)
    );

    assign in_range   = ({1'b0, I_Grt} < NE_L);
    // grt_q is one-hot on the holder, so masking picks out only its release
    // bit; foreign releases and releases while idle (grt_q == 0) vanish.
    assign holder_rls = |(I_Rls & grt_q);

    always_comb begin
        state_d = state_q;
        grt_d   = grt_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (I_Vld) begin
                    if (in_range) begin
                        grt_d   = dec_grt;
                        idx_d   = I_Grt;
                        cnt_d   = '0;
                        state_d = GRANT;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end

            GRANT: begin
                cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
                // Release is checked first so it wins over a same-cycle
                // timeout and suppresses the timeout pulse.
                if (holder_rls || (cnt_q == CNT_LAST)) begin
                    to_d    = ~holder_rls;
                    grt_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                grt_d   = '0;
                idx_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grt_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grt_q   <= grt_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end

    assign O_Grt     = grt_q;
    assign O_Idx     = idx_q;
    assign O_Busy    = (state_q == GRANT);
    assign O_Rdy     = (state_q == IDLE);
    assign O_Timeout = to_q;
    assign O_Err     = err_q;

endmodule
